weight_sequencer: RTL

Upstream stage of `weight_controller`. Walks the (output-depth pair, input-depth) loop nest of one convolution layer and issues one `(od1, id)` request per tile pair. It paces issue on a per-tile acknowledge from the PE array and reports completion. Its `weight_od1_o` and `weight_id_o` drive `weight_od1_i` and `weight_id_i` of `weight_controller`; `total_od_o` drives its `total_od_i`.

---
 rtl/weight_pkg.sv | 16 +
 rtl/weight_sequencer_if.sv | 32 +++
 rtl/nested_loop_counter.sv | 49 ++++
 rtl/weight_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared types and widths for the weight request sequencer
package weight_pkg;

    localparam int OD_W    = 8;
    localparam int ID_W    = 4;
    localparam int CNT_W   = 12;
    localparam int OD_STEP = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/weight_sequencer_if.sv
// rtl/weight_sequencer_if.sv - control, tile handshake and index bundle of the weight sequencer
interface weight_sequencer_if #(
    parameter int OD_W  = weight_pkg::OD_W,
    parameter int ID_W  = weight_pkg::ID_W,
    parameter int CNT_W = weight_pkg::CNT_W
);
    logic              start_i;
    logic              abort_i;
    logic [OD_W-1:0]   total_od_i;
    logic [ID_W:0]     total_id_i;
    logic              tile_ack_i;
    logic [OD_W-1:0]   weight_od1_o;
    logic [ID_W-1:0]   weight_id_o;
    logic              od2_valid_o;
    logic [OD_W-1:0]   total_od_o;
    logic              weight_req_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  tile_cnt_o;

    modport master (
        output start_i, abort_i, total_od_i, total_id_i, tile_ack_i,
        input  weight_od1_o, weight_id_o, od2_valid_o, total_od_o,
               weight_req_o, busy_o, done_o, tile_cnt_o
    );

    modport slave (
        input  start_i, abort_i, total_od_i, total_id_i, tile_ack_i,
        output weight_od1_o, weight_id_o, od2_valid_o, total_od_o,
               weight_req_o, busy_o, done_o, tile_cnt_o
    );
endinterface

// File: rtl/nested_loop_counter.sv
// rtl/nested_loop_counter.sv - inner/outer index counter; outer steps by OD_STEP
module nested_loop_counter
    import weight_pkg::*;
#(
    parameter int IN_W  = ID_W,
    parameter int OUT_W = OD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [IN_W:0]    inner_lim,
    input  logic [OUT_W-1:0] outer_lim,
    output logic [IN_W-1:0]  inner,
    output logic [OUT_W-1:0] outer,
    output logic             last
);
    logic [IN_W-1:0]  inner_q;
    logic [OUT_W-1:0] outer_q;
    logic [OUT_W:0]   next_outer;
    logic             inner_wrap;
    logic             outer_done;

    // One extra bit on both compares so the top index never wraps back to 0
    assign inner_wrap = ({1'b0, inner_q} + (IN_W+1)'(1)) >= inner_lim;
    assign next_outer = {1'b0, outer_q} + (OUT_W+1)'(OD_STEP);
    assign outer_done = next_outer >= {1'b0, outer_lim};
    assign last       = inner_wrap && outer_done;

    assign inner = inner_q;
    assign outer = outer_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_q <= '0;
            outer_q <= '0;
        end else if (clear) begin
            inner_q <= '0;
            outer_q <= '0;
        end else if (advance) begin
            if (!inner_wrap) begin
                inner_q <= inner_q + IN_W'(1);
            end else begin
                inner_q <= '0;
                outer_q <= next_outer[OUT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/weight_sequencer.sv
// rtl/weight_sequencer.sv - walks (od pair, id) tiles of a layer, one request per acknowledged tile
module weight_sequencer
    import weight_pkg::*;
#(
    parameter int OD_W  = weight_pkg::OD_W,
    parameter int ID_W  = weight_pkg::ID_W,
    parameter int CNT_W = weight_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    weight_sequencer_if.slave  bus
);
    seq_state_t       state;
    logic [OD_W-1:0]  tot_od_q;
    logic [ID_W:0]    tot_id_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic [OD_W-1:0]  od1;
    logic [ID_W-1:0]  id;
    logic             last;
    logic             clear;
    logic             advance;

    // Abort wins over start and ack, so the counter must not move on that edge either
    assign clear   = (state == IDLE) && bus.start_i && !bus.abort_i;
    assign advance = (state == WAIT) && bus.tile_ack_i && !bus.abort_i && !last;

    nested_loop_counter #(
        .IN_W  (ID_W),
        .OUT_W (OD_W)
    ) u_loop (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (clear),
        .advance   (advance),
        .inner_lim (tot_id_q),
        .outer_lim (tot_od_q),
        .inner     (id),
        .outer     (od1),
        .last      (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tot_od_q <= '0;
            tot_id_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            if (bus.abort_i) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start_i) begin
                            tot_od_q <= bus.total_od_i;
                            tot_id_q <= bus.total_id_i;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            if (bus.total_od_i == '0 || bus.total_id_i == '0) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= ISSUE;
                                req_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (bus.tile_ack_i) begin
                            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                            if (last) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= ISSUE;
                                req_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.weight_od1_o = od1;
    assign bus.weight_id_o  = id;
    assign bus.od2_valid_o  = ({1'b0, od1} + (OD_W+1)'(1)) < {1'b0, tot_od_q};
    assign bus.total_od_o   = tot_od_q;
    assign bus.weight_req_o = req_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.tile_cnt_o   = cnt_q;
endmodule
